// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner raises DONE; priority then rotates to the
// requester after the owner, with a zero-bubble handoff when others wait.
// Optional forced release after MAX_HOLD cycles: define RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [7:0] GNT,
  output logic       GNT_VALID,
  output logic [2:0] GNT_ID,
  output logic       TIMEOUT
);

  // The hold counter is 8 bits wide, so the hold limit must fit in it.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_arbiter8: MAX_HOLD must be within 1..255");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t     state_q;
  logic [7:0] gnt_q;
  logic [2:0] gnt_id_q;
  logic [2:0] ptr_q;
  logic       timeout_q;

  logic [2:0] ptr_adv;
  logic [7:0] req_masked;
  logic [3:0] idle_pick;
  logic [3:0] hand_pick;
  logic       hold_expired;
  logic       do_release;

  // Returns {found, index} of the first set request scanning from ptr upward,
  // wrapping modulo 8.
  function automatic logic [3:0] pick(input logic [7:0] req,
                                      input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!res[3] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Winner selection for a fresh grant from IDLE and for a handoff on release;
  // the handoff excludes the outgoing owner and starts just after it.
  always_comb begin
    ptr_adv    = gnt_id_q + 3'd1;
    req_masked = REQ & ~gnt_q;
    idle_pick  = pick(REQ, ptr_q);
    hand_pick  = pick(req_masked, ptr_adv);
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;

  // DONE on the limit cycle wins, so the forced-release path stays silent.
  always_comb begin
    hold_expired = (cnt_q == 8'(MAX_HOLD - 1)) && !DONE;
  end
`else
  always_comb begin
    hold_expired = 1'b0;
  end
`endif

  // A release is requested by the owner or forced by the hold limit.
  always_comb begin
    do_release = DONE | hold_expired;
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (idle_pick[3]) begin
            state_q  <= ST_GRANT;
            gnt_q    <= 8'd1 << idle_pick[2:0];
            gnt_id_q <= idle_pick[2:0];
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (do_release) begin
            ptr_q     <= ptr_adv;
            timeout_q <= hold_expired;
            if (hand_pick[3]) begin
              gnt_q    <= 8'd1 << hand_pick[2:0];
              gnt_id_q <= hand_pick[2:0];
`ifdef RR_ARB_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = |gnt_q;
  assign GNT_ID    = gnt_id_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       CLK;
  logic       RST_N;
  logic [7:0] REQ;
  logic       DONE;
  logic [7:0] GNT;
  logic       GNT_VALID;
  logic [2:0] GNT_ID;
  logic       TIMEOUT;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_owner;   // -1 when nobody holds the resource
  int m_last;    // last owner index (GNT_ID)
  int m_ptr;
  int m_hold;    // cycles the current grant has been held
  int m_to;

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .DONE      (DONE),
    .GNT       (GNT),
    .GNT_VALID (GNT_VALID),
    .GNT_ID    (GNT_ID),
    .TIMEOUT   (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_tests++;
    if (observed != expected) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int first_from(input int req, input int ptr);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (ptr + k) % 8;
      if (((req >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 0;
  endtask

  task automatic model_edge(input int req, input int done);
    int tmo;
    int rest;
    m_to = 0;
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = first_from(req, m_ptr);
        m_last  = m_owner;
        m_hold  = 0;
      end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      tmo = (m_hold == HOLD - 1 && done == 0) ? 1 : 0;
`else
      tmo = 0;
`endif
      if (done != 0 || tmo != 0) begin
        m_ptr = (m_last + 1) % 8;
        m_to  = tmo;
        rest  = req & ~(1 << m_last);
        if (rest != 0) begin
          m_owner = first_from(rest, m_ptr);
          m_last  = m_owner;
          m_hold  = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".gnt"},   int'(GNT),       (m_owner < 0) ? 0 : (1 << m_owner));
    check_eq({tag, ".valid"}, int'(GNT_VALID), (m_owner < 0) ? 0 : 1);
    check_eq({tag, ".id"},    int'(GNT_ID),    m_last);
    check_eq({tag, ".tmo"},   int'(TIMEOUT),   m_to);
    check_eq({tag, ".onehot"}, int'($onehot0(GNT)), 1);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check #1 later.
  task automatic cycle(input logic [7:0] r, input logic d, input string tag);
    REQ  = r;
    DONE = d;
    @(posedge CLK);
    model_edge(int'(r), int'(d));
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    REQ   = '0;
    DONE  = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST_N   = 1'b1;
    REQ     = '0;
    DONE    = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 1: idle with no requests, then a single request from requester 4
    for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, "idle");
    cycle(8'h10, 1'b0, "first");
    check_eq("first.gnt_const", int'(GNT), 'h10);
    check_eq("first.id_const", int'(GNT_ID), 4);
    cycle(8'h10, 1'b1, "first_done");

    // 2: all requesting, DONE every third cycle -> 0..7,0 rotation
    do_reset();
    cycle(8'hFF, 1'b0, "rot_start");
    for (int g = 0; g < 9; g++) begin
      check_eq("rot.id_const", int'(GNT_ID), g % 8);
      cycle(8'hFF, 1'b0, "rot");
      cycle(8'hFF, 1'b0, "rot");
      cycle(8'hFF, 1'b1, "rot_done");
      check_eq("rot.nobubble", int'(GNT_VALID), 1);
    end

    // 3: owner 7 with requester 0 waiting -> wrap to 0, then back to 7
    do_reset();
    cycle(8'h80, 1'b0, "wrap_own7");
    check_eq("wrap.id7", int'(GNT_ID), 7);
    cycle(8'h81, 1'b1, "wrap_rel");
    check_eq("wrap.gnt0", int'(GNT), 'h01);
    cycle(8'h81, 1'b1, "wrap_rel2");
    check_eq("wrap.gnt7", int'(GNT), 'h80);
    cycle(8'h00, 1'b1, "wrap_end");

    // 4: lone requester is re-granted after exactly one idle cycle
    do_reset();
    cycle(8'h04, 1'b0, "lone");
    cycle(8'h04, 1'b1, "lone_rel");
    check_eq("lone.gap", int'(GNT), 0);
    cycle(8'h04, 1'b0, "lone_again");
    check_eq("lone.regrant", int'(GNT), 'h04);

    // 5: asynchronous reset mid-cycle while requester 2 owns the grant
    do_reset();
    cycle(8'h0C, 1'b0, "ar_grant");
    cycle(8'h0C, 1'b0, "ar_hold");
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("ar.gnt_async", int'(GNT), 0);
    check_eq("ar.valid_async", int'(GNT_VALID), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cycle(8'h0C, 1'b0, "ar_after");
    check_eq("ar.gnt2", int'(GNT), 'h04);

    // 6: hold limit with requesters 0 and 1 and no DONE
    do_reset();
    for (int i = 0; i < 7; i++) cycle(8'h03, 1'b0, "hold");
    cycle(8'h00, 1'b1, "hold_end");

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      logic       d;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom_range(0, 255));
        1:       r = 8'd1 << $urandom_range(0, 7);
        2:       r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
        default: r = 8'h00;
      endcase
      d = ($urandom_range(0, 2) == 0);
      cycle(r, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
